// File: rtl/uart_report_pkg.sv
// Shared types and constants for the UART result reporter.
// Holds FSM encodings, ASCII constants and the "Answer =" prefix ROM.
package uart_report_pkg;

   typedef enum logic [6:0] {
      S_IDLE   = 7'b0000001,
      S_CONV   = 7'b0000010,
      S_PREFIX = 7'b0000100,
      S_DIGIT  = 7'b0001000,
      S_CR     = 7'b0010000,
      S_LF     = 7'b0100000,
      S_DRAIN  = 7'b1000000
   } rep_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   localparam logic [7:0] CHAR_CR   = 8'd13;
   localparam logic [7:0] CHAR_LF   = 8'd10;
   localparam logic [7:0] CHAR_ZERO = 8'd48;

   localparam int PREFIX_LEN = 8;
   localparam logic [8*PREFIX_LEN-1:0] PREFIX_INIT = "Answer =";

   // Byte 0 of the prefix is the leftmost character of the literal.
   function automatic logic [7:0] prefix_byte(input logic [2:0] idx);
      return PREFIX_INIT[8*(PREFIX_LEN-1-int'(idx)) +: 8];
   endfunction

endpackage

// File: rtl/uart_result_reporter_if.sv
// Result push handshake between the inference core and the reporter.
// Producer drives result/valid; the reporter answers with ready.
interface uart_result_reporter_if #(
   parameter int CLASS_W = 8
);
   logic [CLASS_W-1:0] i_Result;
   logic               i_Result_Valid;
   logic               o_Result_Ready;

   modport master (
      output i_Result,
      output i_Result_Valid,
      input  o_Result_Ready
   );

   modport slave (
      input  i_Result,
      input  i_Result_Valid,
      output o_Result_Ready
   );
endinterface

// File: rtl/UART_TX.sv
// 8N1 UART transmitter, line idle high.
// o_Tx_Active rises the cycle after a start request is seen.
module UART_TX
   import uart_report_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [7:0] i_Tx_Byte,
   input  logic       i_Tx_start,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t   st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]  bit_r, bit_n;
   logic [7:0]  sh, sh_n;
   logic        done_n;
   logic        ser_n;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= TX_IDLE;
         cnt         <= '0;
         bit_r       <= '0;
         sh          <= '0;
         o_Tx_Active <= 1'b0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Done   <= 1'b0;
      end else begin
         st          <= st_n;
         cnt         <= cnt_n;
         bit_r       <= bit_n;
         sh          <= sh_n;
         o_Tx_Active <= (st_n != TX_IDLE);
         o_Tx_Serial <= ser_n;
         o_Tx_Done   <= done_n;
      end
   end

   always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      bit_n  = bit_r;
      sh_n   = sh;
      done_n = 1'b0;
      unique case (st)
         TX_IDLE: begin
            if (i_Tx_start) begin
               sh_n  = i_Tx_Byte;
               cnt_n = '0;
               st_n  = TX_START;
            end
         end
         TX_START: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               bit_n = '0;
               st_n  = TX_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_DATA: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               bit_n = bit_r + 1'b1;
               if (bit_r == 3'd7) begin
                  st_n = TX_STOP;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (cnt == LAST) begin
               cnt_n  = '0;
               st_n   = TX_IDLE;
               done_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: st_n = TX_IDLE;
      endcase
      // Line level follows the state being entered so it stays registered.
      ser_n = 1'b1;
      if (st_n == TX_START) begin
         ser_n = 1'b0;
      end else if (st_n == TX_DATA) begin
         ser_n = sh_n[bit_n];
      end
   end

endmodule

// File: rtl/uart_report_fifo.sv
// Result FIFO, DEPTH x WIDTH, with occupancy count.
// Push and pop in one cycle are both honoured, also when full.
module uart_report_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_result_reporter.sv
// Queues classifier results and prints "Answer =<decimal>" lines over UART.
// Define REPORTER_CRLF_EN to end lines with CR LF instead of CR alone.
module uart_result_reporter
   import uart_report_pkg::*;
#(
   parameter int CLASS_W      = 8,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 87
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   uart_result_reporter_if.slave  res_if,
   output logic                   o_Tx_Serial,
   output logic                   o_Idle,
   output logic                   o_Done,
   output logic [$clog2(DEPTH):0] o_Count
);
   rep_state_t state, state_n;

   logic [7:0]         val_r, val_n;
   logic [1:0]         h_r, h_n;
   logic [3:0]         t_r, t_n;
   logic [2:0]         idx, idx_n;
   logic               tx_start, tx_start_n;
   logic [7:0]         tx_byte, tx_byte_n;
   logic               done_n;
   logic               tx_active;
   logic               tx_done;
   logic               tx_ready;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [CLASS_W-1:0] head;

   assign res_if.o_Result_Ready = !full;
   assign push     = res_if.i_Result_Valid && !full;
   assign tx_ready = !tx_active && !tx_start;
   assign o_Idle   = (state == S_IDLE) && empty;

   uart_report_fifo #(
      .WIDTH (CLASS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .rst_n (Rst_n),
      .push  (push),
      .wdata (res_if.i_Result),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (o_Count)
   );

   UART_TX #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .sysclk      (Clk),
      .rst_n       (Rst_n),
      .i_Tx_Byte   (tx_byte),
      .i_Tx_start  (tx_start),
      .o_Tx_Active (tx_active),
      .o_Tx_Serial (o_Tx_Serial),
      .o_Tx_Done   (tx_done)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= S_IDLE;
         val_r    <= '0;
         h_r      <= '0;
         t_r      <= '0;
         idx      <= '0;
         tx_start <= 1'b0;
         tx_byte  <= '0;
         o_Done   <= 1'b0;
      end else begin
         state    <= state_n;
         val_r    <= val_n;
         h_r      <= h_n;
         t_r      <= t_n;
         idx      <= idx_n;
         tx_start <= tx_start_n;
         tx_byte  <= tx_byte_n;
         o_Done   <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      val_n      = val_r;
      h_n        = h_r;
      t_n        = t_r;
      idx_n      = idx;
      tx_start_n = 1'b0;
      tx_byte_n  = tx_byte;
      done_n     = 1'b0;
      pop        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               val_n   = 8'(head);
               h_n     = '0;
               t_n     = '0;
               state_n = S_CONV;
            end
         end
         S_CONV: begin
            if (val_r >= 8'd100) begin
               val_n = val_r - 8'd100;
               h_n   = h_r + 2'd1;
            end else if (val_r >= 8'd10) begin
               val_n = val_r - 8'd10;
               t_n   = t_r + 4'd1;
            end else begin
               idx_n   = '0;
               state_n = S_PREFIX;
            end
         end
         S_PREFIX: begin
            if (tx_ready) begin
               tx_start_n = 1'b1;
               tx_byte_n  = prefix_byte(idx);
               idx_n      = idx + 3'd1;
               if (idx == 3'(PREFIX_LEN - 1)) begin
                  idx_n   = '0;
                  state_n = S_DIGIT;
               end
            end
         end
         S_DIGIT: begin
            // idx walks hundreds, tens, units; leading zeros are skipped.
            if (idx == 3'd0) begin
               if (h_r == '0) begin
                  idx_n = 3'd1;
               end else if (tx_ready) begin
                  tx_start_n = 1'b1;
                  tx_byte_n  = CHAR_ZERO + {6'd0, h_r};
                  idx_n      = 3'd1;
               end
            end else if (idx == 3'd1) begin
               if (h_r == '0 && t_r == '0) begin
                  idx_n = 3'd2;
               end else if (tx_ready) begin
                  tx_start_n = 1'b1;
                  tx_byte_n  = CHAR_ZERO + {4'd0, t_r};
                  idx_n      = 3'd2;
               end
            end else if (tx_ready) begin
               tx_start_n = 1'b1;
               tx_byte_n  = CHAR_ZERO + val_r;
               idx_n      = '0;
               state_n    = S_CR;
            end
         end
         S_CR: begin
            if (tx_ready) begin
               tx_start_n = 1'b1;
               tx_byte_n  = CHAR_CR;
`ifdef REPORTER_CRLF_EN
               state_n    = S_LF;
`else
               state_n    = S_DRAIN;
`endif
            end
         end
`ifdef REPORTER_CRLF_EN
         S_LF: begin
            if (tx_ready) begin
               tx_start_n = 1'b1;
               tx_byte_n  = CHAR_LF;
               state_n    = S_DRAIN;
            end
         end
`endif
         S_DRAIN: begin
            if (tx_ready || tx_done) begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_result_reporter.sv
// Directed bench: decodes both UART lines and compares printed strings.
// Instance 0 uses CLASS_W=8, instance 1 uses CLASS_W=1.
module tb_uart_result_reporter;
   localparam int CPB = 4;
`ifdef REPORTER_CRLF_EN
   localparam string TERM = "<CR><LF>";
   localparam logic [7:0] EOL = 8'd10;
`else
   localparam string TERM = "<CR>";
   localparam logic [7:0] EOL = 8'd13;
`endif

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b1;
   logic       tx0, tx1, idle0, idle1, done0, done1;
   logic [2:0] cnt0, cnt1;

   uart_result_reporter_if #(.CLASS_W(8)) if0 ();
   uart_result_reporter_if #(.CLASS_W(1)) if1 ();

   uart_result_reporter #(
      .CLASS_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB)
   ) dut0 (
      .Clk(Clk), .Rst_n(Rst_n), .res_if(if0),
      .o_Tx_Serial(tx0), .o_Idle(idle0),
      .o_Done(done0), .o_Count(cnt0)
   );

   uart_result_reporter #(
      .CLASS_W(1), .DEPTH(4), .CLKS_PER_BIT(CPB)
   ) dut1 (
      .Clk(Clk), .Rst_n(Rst_n), .res_if(if1),
      .o_Tx_Serial(tx1), .o_Idle(idle1),
      .o_Done(done1), .o_Count(cnt1)
   );

   always #5 Clk = ~Clk;

   int    vectors = 0;
   int    errors = 0;
   int    dcnt0 = 0;
   int    dcnt1 = 0;
   int    full_seen = 0;
   int    rdy_bad = 0;
   int    frame_err = 0;
   int    nbytes [2];
   string cur [2];
   string lines0 [$];
   string lines1 [$];

   always @(posedge Clk) begin
      if (done0) dcnt0++;
      if (done1) dcnt1++;
   end

   always @(negedge Clk) begin
      if (Rst_n) begin
         if (cnt0 == 3'd4 && !if0.o_Result_Ready) full_seen++;
         if ((cnt0 == 3'd4) == if0.o_Result_Ready) rdy_bad++;
      end
   end

   task automatic check(input string tag, input string got, input string exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
      end
   endtask

   function automatic string d2s(input int v);
      return $sformatf("%0d", v);
   endfunction

   function automatic logic ser(input int sel);
      return (sel != 0) ? tx1 : tx0;
   endfunction

   function automatic string ch2s(input logic [7:0] b);
      if (b == 8'd13) return "<CR>";
      if (b == 8'd10) return "<LF>";
      return $sformatf("%c", b);
   endfunction

   function automatic string line_at(input int sel, input int i);
      if (sel == 0) return (i < lines0.size()) ? lines0[i] : "<none>";
      return (i < lines1.size()) ? lines1[i] : "<none>";
   endfunction

   task automatic uart_rx(input int sel);
      logic [7:0] b;
      b = '0;
      do @(negedge Clk); while (!(Rst_n && ser(sel) === 1'b0));
      repeat (CPB/2) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge Clk);
         b[i] = ser(sel);
      end
      repeat (CPB) @(negedge Clk);
      if (ser(sel) !== 1'b1) frame_err++;
      nbytes[sel]++;
      cur[sel] = {cur[sel], ch2s(b)};
      if (b == EOL) begin
         if (sel == 0) lines0.push_back(cur[0]);
         else lines1.push_back(cur[1]);
         cur[sel] = "";
      end
   endtask

   initial forever uart_rx(0);
   initial forever uart_rx(1);

   task automatic push(input int sel, input int v);
      logic rdy;
      if (sel == 0) begin
         if0.i_Result = 8'(v);
         if0.i_Result_Valid = 1'b1;
      end else begin
         if1.i_Result = v[0];
         if1.i_Result_Valid = 1'b1;
      end
      for (int k = 0; k < 5000; k++) begin
         rdy = (sel == 0) ? if0.o_Result_Ready : if1.o_Result_Ready;
         if (rdy) break;
         @(negedge Clk);
      end
      if (!rdy) check("push_timeout", "0", "1");
      @(negedge Clk);
   endtask

   task automatic wait_lines(input int sel, input int n);
      for (int k = 0; k < 20000; k++) begin
         if (((sel == 0) ? lines0.size() : lines1.size()) >= n) break;
         @(negedge Clk);
      end
   endtask

   int d0, f0, r0, nb;
   int vals [6] = '{3, 42, 199, 9, 250, 17};

   initial begin
      nbytes[0] = 0;
      nbytes[1] = 0;
      cur[0] = "";
      cur[1] = "";
      if0.i_Result = '0;
      if0.i_Result_Valid = 1'b0;
      if1.i_Result = '0;
      if1.i_Result_Valid = 1'b0;
      #2 Rst_n = 1'b0;
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      check("rst_tx", d2s(int'(tx0)), "1");
      check("rst_ready", d2s(int'(if0.o_Result_Ready)), "1");
      check("rst_idle", d2s(int'(idle0)), "1");
      check("rst_count", d2s(int'(cnt0)), "0");
      check("rst_done", d2s(int'(done0)), "0");

      d0 = dcnt0;
      push(0, 0);
      if0.i_Result_Valid = 1'b0;
      wait_lines(0, 1);
      check("t1_line", line_at(0, 0), {"Answer =0", TERM});
      repeat (20) @(negedge Clk);
      check("t1_done", d2s(dcnt0 - d0), "1");
      check("t1_idle", d2s(int'(idle0)), "1");

      d0 = dcnt0;
      push(0, 205);
      push(0, 10);
      push(0, 100);
      if0.i_Result_Valid = 1'b0;
      wait_lines(0, 4);
      check("t2_l0", line_at(0, 1), {"Answer =205", TERM});
      check("t2_l1", line_at(0, 2), {"Answer =10", TERM});
      check("t2_l2", line_at(0, 3), {"Answer =100", TERM});
      repeat (20) @(negedge Clk);
      check("t2_done", d2s(dcnt0 - d0), "3");

      f0 = full_seen;
      r0 = rdy_bad;
      foreach (vals[i]) push(0, vals[i]);
      if0.i_Result_Valid = 1'b0;
      wait_lines(0, 10);
      foreach (vals[i])
         check($sformatf("t3_l%0d", i), line_at(0, 4 + i),
               {"Answer =", d2s(vals[i]), TERM});
      check("t3_full", d2s(int'(full_seen > f0)), "1");
      check("t3_ready", d2s(rdy_bad - r0), "0");
      repeat (20) @(negedge Clk);

      nb = nbytes[0];
      push(0, 123);
      push(0, 45);
      if0.i_Result_Valid = 1'b0;
      for (int k = 0; k < 2000 && nbytes[0] < nb + 3; k++) @(negedge Clk);
      repeat (8) @(negedge Clk);
      d0 = dcnt0;
      Rst_n = 1'b0;
      #1;
      check("t4_tx", d2s(int'(tx0)), "1");
      check("t4_count", d2s(int'(cnt0)), "0");
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (60) @(negedge Clk);
      check("t4_nodone", d2s(dcnt0 - d0), "0");
      cur[0] = "";
      lines0.delete();
      push(0, 7);
      if0.i_Result_Valid = 1'b0;
      wait_lines(0, 1);
      check("t4_line", line_at(0, 0), {"Answer =7", TERM});
      repeat (800) @(negedge Clk);
      check("t4_nlines", d2s(lines0.size()), "1");

      push(0, 255);
      if0.i_Result_Valid = 1'b0;
      wait_lines(0, 2);
      check("t5_line", line_at(0, 1), {"Answer =255", TERM});

      d0 = dcnt1;
      push(1, 1);
      push(1, 0);
      if1.i_Result_Valid = 1'b0;
      wait_lines(1, 2);
      check("t6_l0", line_at(1, 0), {"Answer =1", TERM});
      check("t6_l1", line_at(1, 1), {"Answer =0", TERM});
      repeat (20) @(negedge Clk);
      check("t6_done", d2s(dcnt1 - d0), "2");
      check("frame", d2s(frame_err), "0");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
